// File: rtl/alu_shift_right_iter.sv
// Iterative 32-bit right shifter: up to 4 bit positions per cycle, logical or arithmetic fill.
// Define ALU_SHIFT_RIGHT_ROTATE_EN to add the rotate input and rotate-right datapath.
module alu_shift_right_iter (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [5:0]  shift,
    input  logic        arith,
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
    input  logic        rotate,
`endif
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] out_q, out_d;
    logic [5:0]  rem_q, rem_d;
    logic        fill_q, fill_d;
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
    logic        rot_q, rot_d;
`endif

    logic [5:0]  n_eff;
    logic [2:0]  step;
    logic [3:0]  hi_bits;
    logic [31:0] shifted;

    // Effective amount: anything >= 32 saturates the result, so clamp to 32.
    always_comb begin
        n_eff = shift[5] ? 6'd32 : shift;
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
        if (rotate) begin
            n_eff = {1'b0, shift[4:0]};
        end
`endif
    end

    // Bits entering at the top: sign/zero fill, or the bits leaving the bottom when rotating.
    always_comb begin
        step    = (rem_q >= 6'd4) ? 3'd4 : rem_q[2:0];
        hi_bits = {4{fill_q}};
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
        if (rot_q) begin
            hi_bits = work_q[3:0];
        end
`endif
        case (step)
            3'd1:    shifted = {hi_bits[0],   work_q[31:1]};
            3'd2:    shifted = {hi_bits[1:0], work_q[31:2]};
            3'd3:    shifted = {hi_bits[2:0], work_q[31:3]};
            3'd4:    shifted = {hi_bits[3:0], work_q[31:4]};
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    work_d = in;
                    rem_d  = n_eff;
                    fill_d = arith & in[31];
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
                    rot_d  = rotate;
`endif
                    if (n_eff == 6'd0) begin
                        out_d   = in;
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                work_d = shifted;
                rem_d  = rem_q - {3'd0, step};
                if (rem_d == 6'd0) begin
                    out_d   = shifted;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            work_q  <= 32'd0;
            out_q   <= 32'd0;
            rem_q   <= 6'd0;
            fill_q  <= 1'b0;
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_alu_shift_right_iter.sv
// Randomized and directed bench for alu_shift_right_iter against a plain-arithmetic model.
module tb_alu_shift_right_iter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in = 32'd0;
    logic [5:0]  shift = 6'd0;
    logic        arith = 1'b0;
    logic        rotate = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_shift_right_iter dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .in    (in),
        .shift (shift),
        .arith (arith),
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
        .rotate(rotate),
`endif
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int eff_n(input logic [5:0] s, input logic r);
        if (r) return int'(s[4:0]);
        return (int'(s) >= 32) ? 32 : int'(s);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [5:0] s,
                                          input logic ar, input logic r);
        logic [63:0] ext;
        int n;
        n = eff_n(s, r);
        if (r) ext = {a, a};
        else if (ar && a[31]) ext = {32'hFFFFFFFF, a};
        else ext = {32'd0, a};
        ext = ext >> n;
        return ext[31:0];
    endfunction

    // Called #1 after a posedge; returns after done is seen (or budget spent).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [5:0] s,
                          input logic ar, input logic r, input bit hold_chk);
        int n, m, bc, exp_cyc;
        logic [31:0] exp;
        n = eff_n(s, r);
        exp = model(a, s, ar, r);
        exp_cyc = (n + 3) / 4;
        in = a; shift = s; arith = ar; rotate = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in = $urandom;
        m = 0; bc = 0;
        while (!done && m < 20) begin
            bc += int'(busy);
            @(posedge clk); #1;
            m++;
        end
        check({tag, " latency"}, 32'(m + 1), 32'(exp_cyc + 1));
        check({tag, " busy_cycles"}, 32'(bc), 32'(exp_cyc));
        check({tag, " out"}, out, exp);
        if (hold_chk) begin
            @(posedge clk); #1;
            check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
            check({tag, " out_hold"}, out, exp);
        end
    endtask

    initial begin
        int m;
        bit seen;
        logic [31:0] a;
        logic [5:0]  s;
        logic        ar, r;

        #2;
        check("reset out", out, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        // Start sampled on the very first edge after reset release.
        run_op("first", 32'd200, 6'd3, 1'b0, 1'b0, 1'b1);
        run_op("arith31", 32'h80000000, 6'd31, 1'b1, 1'b0, 1'b1);
        run_op("log32", 32'hFFFFFFFF, 6'b100000, 1'b0, 1'b0, 1'b1);
        run_op("ari32", 32'hFFFFFFFF, 6'b100000, 1'b1, 1'b0, 1'b1);
        run_op("ari63", 32'h8000F000, 6'd63, 1'b1, 1'b0, 1'b1);
        run_op("zero", 32'h1234, 6'd0, 1'b0, 1'b0, 1'b1);
        run_op("ari_pos", 32'h7000_0000, 6'd5, 1'b1, 1'b0, 1'b1);
        // Back-to-back: start while done is high.
        run_op("b2b_a", 32'hDEADBEEF, 6'd4, 1'b0, 1'b0, 1'b0);
        run_op("b2b_b", 32'hCAFEF00D, 6'd9, 1'b1, 1'b0, 1'b1);
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
        run_op("rot1", 32'd1, 6'd1, 1'b0, 1'b1, 1'b1);
        run_op("rot33", 32'd1, 6'd33, 1'b1, 1'b1, 1'b1);
`endif

        // Start pulse mid-shift must be ignored.
        in = 32'hF0F0_1234; shift = 6'd32; arith = 1'b0; rotate = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in = 32'h0000_FFFF; shift = 6'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = 0;
        while (!done && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        check("ignore latency", 32'(m + 4 + 1), 32'd9);
        check("ignore out", out, 32'd0);

        // Reset mid-shift aborts without a done.
        @(posedge clk); #1;
        in = 32'h8765_4321; shift = 6'd20; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        check("abort out", out, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= done;
        end
        check("abort no_done", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            s  = 6'($urandom_range(0, 63));
            ar = 1'($urandom);
`ifdef ALU_SHIFT_RIGHT_ROTATE_EN
            r  = 1'($urandom);
`else
            r  = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), a, s, ar, r, (i % 4) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
